frame_link_arbiter: RTL and testbench
=====================================

Name: frame_link_arbiter

Overview:
Sits in front of the frame core and shares it between the jawny and tajny ingress sides. Each side has a one-frame holding buffer. The block grants the core round-robin, presents one frame at a time, and waits for the core's confirm. It retries on ERROR or timeout, flushes on FATAL_ERROR, and reports a per-side completion code back to the originating side.

Parameters:
DATA_SIZE, 64, payload bytes per frame
PREAMBLE_SIZE, 7, header bytes per frame
CRC_SIZE, 4, CRC bytes per frame
FRAME_W, (PREAMBLE_SIZE+DATA_SIZE+CRC_SIZE)*8 = 600, frame width in bits; bit 0 is MSB of type byte
MAX_RETRY, 3, re-issues allowed after the first attempt
TIMEOUT_CYCLES, 1024, WAIT_CONF cycles before a timeout
BACKOFF_CYCLES, 450, idle cycles before a re-issue

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
j_frame  in  FRAME_W  jawny ingress frame
j_valid  in  1  jawny frame offered
j_ready  out  1  jawny buffer empty
t_frame  in  FRAME_W  tajny ingress frame
t_valid  in  1  tajny frame offered
t_ready  out  1  tajny buffer empty
core_frame  out  FRAME_W  frame presented to core (shared by both sides)
core_fin_j_valid  out  1  one-cycle pulse: core_frame came from jawny
core_fin_t_valid  out  1  one-cycle pulse: core_frame came from tajny
core_conf_jawny  in  1  core confirm for jawny transaction
core_conf_tajny  in  1  core confirm for tajny transaction
core_conf_code  in  8  0x05 OKAY, 0x04 ERROR, 0x08 FATAL_ERROR
j_done  out  1  one-cycle pulse: jawny frame finished
t_done  out  1  one-cycle pulse: tajny frame finished
done_code  out  8  final code, valid with j_done/t_done
busy  out  1  high whenever state != IDLE
timeout_pulse  out  1  one-cycle pulse on each confirm timeout
fatal_pulse  out  1  one-cycle pulse on FATAL_ERROR flush
stat_ok  out  16  OKAY count (optional feature)
stat_err  out  16  final-ERROR count (optional feature)

Behaviour:
- Reset state: all outputs 0 except j_ready=1 and t_ready=1. Buffers empty; state IDLE; rr pointer = jawny-first; retry and timer counters 0.
- Ingress: buffer loads on valid&&ready; ready deasserts the next cycle. ready is registered, so a freed buffer cannot refill in the same cycle it releases.
- State machine: IDLE, ISSUE, WAIT_CONF, BACKOFF, DONE.
- IDLE:
  - If either buffer is full, grant it (one full buffer) or the side not last granted (both full), then go to ISSUE.
  - Each grant updates the rr pointer.
- ISSUE:
  - core_frame = granted buffer; it stays stable from ISSUE until DONE.
  - Pulse the matching core_fin_*_valid for exactly one cycle.
  - Clear the timer, then go to WAIT_CONF.
- WAIT_CONF: timer increments each cycle. Only a confirm for the granted side counts; the other side's confirm is ignored.
  - OKAY: go to DONE with code 0x05.
  - ERROR, or timer == TIMEOUT_CYCLES-1: timeout also pulses timeout_pulse.
    - If retry < MAX_RETRY: retry++, go to BACKOFF.
    - Otherwise: go to DONE with code 0x04.
  - FATAL_ERROR:
    - Flush both buffers, zero retry, reset the rr pointer.
    - Pulse fatal_pulse, and pulse j_done and t_done for any side whose buffer was full, with code 0x08.
    - Go to IDLE.
  - A valid confirm code wins over a timeout in the same cycle.
  - Any unknown code is treated as ERROR.
- BACKOFF: wait BACKOFF_CYCLES cycles, then go to ISSUE with the same frame. Confirms arriving here are ignored.
- DONE:
  - Pulse the granted side's done with done_code.
  - Empty that buffer and zero retry, then go to IDLE.
  - The next grant occurs no earlier than the following cycle.
- Total attempts per frame: MAX_RETRY+1.
- Minimum latency, OKAY confirm in the first WAIT_CONF cycle: ISSUE to done pulse = 3 cycles.
- Reset mid-operation: in-flight frame dropped, no done pulse; everything returns to reset values.

Optional Feature:
ARB_STATS_EN.
- Defined: stat_ok increments at DONE with 0x05; stat_err increments at DONE with 0x04. Both are 16-bit, saturate at 0xFFFF, and clear on rst.
- Undefined: stat_ok and stat_err are tied to 0 and no counter logic is built.

Decomposition:
- Shared package: frame geometry constants (DATA_SIZE, PREAMBLE_SIZE, CRC_SIZE, FRAME_W), confirm codes OKAY/ERROR/FATAL_ERROR, side encoding JAWNY=2'b01/TAJNY=2'b10, and the arbiter state encoding.
- One natural sub-module: frame_hold_buffer, the one-entry valid/ready register instantiated per side.

Test Plan:
- Only jawny offers frame A; core confirms OKAY 1 cycle after core_fin_j_valid -> j_done with done_code 0x05 exactly 3 cycles after ISSUE; j_ready back to 1 next cycle.
- Both sides full out of reset -> jawny issued first, then tajny; repeat with both full -> order alternates j,t,j,t.
- Tajny frame; core answers ERROR three times, then OKAY -> 4 core_fin_t_valid pulses, each ≥450 cycles apart; t_done with code 0x05.
- Jawny frame; core never confirms -> 4 timeout_pulse; j_done with code 0x04 after the 4th timeout.
- Both buffers full, jawny in flight; core returns FATAL_ERROR -> fatal_pulse; j_done and t_done both pulse with code 0x08; both ready=1; state IDLE.
- rst asserted during BACKOFF -> no done pulse; all outputs at reset values next cycle; with ARB_STATS_EN, counters are 0.

Source files
------------

// File: rtl/frame_link_arbiter_pkg.sv
// Shared definitions for the frame link arbiter: frame geometry, core
// confirm codes, side encoding and the arbiter state encoding.
package frame_link_arbiter_pkg;

  localparam int DATA_SIZE     = 64;
  localparam int PREAMBLE_SIZE = 7;
  localparam int CRC_SIZE      = 4;
  localparam int FRAME_W       = (PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE) * 8;

  localparam logic [7:0] CODE_OKAY  = 8'h05;
  localparam logic [7:0] CODE_ERROR = 8'h04;
  localparam logic [7:0] CODE_FATAL = 8'h08;

  typedef logic [1:0] side_t;
  localparam side_t JAWNY = 2'b01;
  localparam side_t TAJNY = 2'b10;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_CONF = 3'd2;
  localparam logic [2:0] ST_BACKOFF   = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

endpackage

// File: rtl/frame_link_arbiter_hold.sv
// One-entry valid/ready holding register for a single ingress side.
// Ready is registered, so a released entry only reopens on the next cycle.
module frame_hold_buffer
  import frame_link_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic               i_valid,
  input  logic               i_release,
  output logic               o_ready,
  output logic               o_full,
  output logic [FRAME_W-1:0] o_frame
);

  logic               r_full;
  logic               r_ready;
  logic [FRAME_W-1:0] r_frame;

  // Capture a frame on handshake; release empties the entry for the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
      r_frame <= '0;
    end else if (i_release) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
    end else if (i_valid && r_ready) begin
      r_full  <= 1'b1;
      r_ready <= 1'b0;
      r_frame <= i_frame;
    end
  end

  assign o_ready = r_ready;
  assign o_full  = r_full;
  assign o_frame = r_frame;

endmodule

// File: rtl/frame_link_arbiter.sv
// Round-robin arbiter sharing the frame core between the jawny and tajny
// ingress sides, with retry/backoff, confirm timeout and fatal flush.
// Optional build macro ARB_STATS_EN adds saturating OKAY / final-ERROR counters.
module frame_link_arbiter
  import frame_link_arbiter_pkg::*;
#(
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BACKOFF_CYCLES = 450
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] j_frame,
  input  logic               j_valid,
  output logic               j_ready,
  input  logic [FRAME_W-1:0] t_frame,
  input  logic               t_valid,
  output logic               t_ready,
  output logic [FRAME_W-1:0] core_frame,
  output logic               core_fin_j_valid,
  output logic               core_fin_t_valid,
  input  logic               core_conf_jawny,
  input  logic               core_conf_tajny,
  input  logic [7:0]         core_conf_code,
  output logic               j_done,
  output logic               t_done,
  output logic [7:0]         done_code,
  output logic               busy,
  output logic               timeout_pulse,
  output logic               fatal_pulse,
  output logic [15:0]        stat_ok,
  output logic [15:0]        stat_err
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(BACKOFF_CYCLES);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BACKOFF_LAST = BW'(BACKOFF_CYCLES - 1);

  logic [2:0]         r_state;
  side_t              r_grant;
  side_t              r_last;
  logic [RW-1:0]      r_retry;
  logic [TW-1:0]      r_timer;
  logic [BW-1:0]      r_backoff;
  logic [FRAME_W-1:0] r_core_frame;
  logic [7:0]         r_code;
  logic [7:0]         r_done_code;
  logic               r_fin_j;
  logic               r_fin_t;
  logic               r_j_done;
  logic               r_t_done;
  logic               r_timeout;
  logic               r_fatal;

  logic               w_j_full;
  logic               w_t_full;
  logic [FRAME_W-1:0] w_j_frame;
  logic [FRAME_W-1:0] w_t_frame;
  logic               w_j_avail;
  logic               w_t_avail;
  logic               w_conf;
  logic               w_timeout;

  // A done pulse doubles as the buffer release, so the entry drains while it is reported
  frame_hold_buffer u_j_buf (
    .clk       (clk),
    .rst       (rst),
    .i_frame   (j_frame),
    .i_valid   (j_valid),
    .i_release (r_j_done),
    .o_ready   (j_ready),
    .o_full    (w_j_full),
    .o_frame   (w_j_frame)
  );

  frame_hold_buffer u_t_buf (
    .clk       (clk),
    .rst       (rst),
    .i_frame   (t_frame),
    .i_valid   (t_valid),
    .i_release (r_t_done),
    .o_ready   (t_ready),
    .o_full    (w_t_full),
    .o_frame   (w_t_frame)
  );

  // A buffer being released this cycle is not eligible for a new grant
  assign w_j_avail = w_j_full & ~r_j_done;
  assign w_t_avail = w_t_full & ~r_t_done;
  assign w_conf    = (r_grant == JAWNY) ? core_conf_jawny : core_conf_tajny;
  assign w_timeout = (r_timer == TIMER_LAST);

  // Arbitration state machine; all outputs are registered single-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'b00;
      r_last       <= TAJNY;
      r_retry      <= '0;
      r_timer      <= '0;
      r_backoff    <= '0;
      r_core_frame <= '0;
      r_code       <= 8'h00;
      r_done_code  <= 8'h00;
      r_fin_j      <= 1'b0;
      r_fin_t      <= 1'b0;
      r_j_done     <= 1'b0;
      r_t_done     <= 1'b0;
      r_timeout    <= 1'b0;
      r_fatal      <= 1'b0;
    end else begin
      r_fin_j     <= 1'b0;
      r_fin_t     <= 1'b0;
      r_j_done    <= 1'b0;
      r_t_done    <= 1'b0;
      r_timeout   <= 1'b0;
      r_fatal     <= 1'b0;
      r_done_code <= 8'h00;
      case (r_state)
        ST_IDLE: begin
          if (w_j_avail && (!w_t_avail || r_last == TAJNY)) begin
            r_grant      <= JAWNY;
            r_last       <= JAWNY;
            r_core_frame <= w_j_frame;
            r_fin_j      <= 1'b1;
            r_state      <= ST_ISSUE;
          end else if (w_t_avail) begin
            r_grant      <= TAJNY;
            r_last       <= TAJNY;
            r_core_frame <= w_t_frame;
            r_fin_t      <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_timer <= '0;
          r_state <= ST_WAIT_CONF;
        end
        ST_WAIT_CONF: begin
          r_timer <= r_timer + 1'b1;
          if (w_conf && core_conf_code == CODE_OKAY) begin
            r_code  <= CODE_OKAY;
            r_state <= ST_DONE;
          end else if (w_conf && core_conf_code == CODE_FATAL) begin
            r_fatal     <= 1'b1;
            r_j_done    <= w_j_full;
            r_t_done    <= w_t_full;
            r_done_code <= CODE_FATAL;
            r_retry     <= '0;
            r_last      <= TAJNY;
            r_state     <= ST_IDLE;
          end else if (w_conf || w_timeout) begin
            r_timeout <= ~w_conf;
            if (r_retry < RETRY_LIMIT) begin
              r_retry   <= r_retry + 1'b1;
              r_backoff <= '0;
              r_state   <= ST_BACKOFF;
            end else begin
              r_code  <= CODE_ERROR;
              r_state <= ST_DONE;
            end
          end
        end
        ST_BACKOFF: begin
          if (r_backoff == BACKOFF_LAST) begin
            r_fin_j <= (r_grant == JAWNY);
            r_fin_t <= (r_grant == TAJNY);
            r_state <= ST_ISSUE;
          end else begin
            r_backoff <= r_backoff + 1'b1;
          end
        end
        ST_DONE: begin
          r_j_done    <= (r_grant == JAWNY);
          r_t_done    <= (r_grant == TAJNY);
          r_done_code <= r_code;
          r_retry     <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core_frame       = r_core_frame;
  assign core_fin_j_valid = r_fin_j;
  assign core_fin_t_valid = r_fin_t;
  assign j_done           = r_j_done;
  assign t_done           = r_t_done;
  assign done_code        = r_done_code;
  assign busy             = (r_state != ST_IDLE);
  assign timeout_pulse    = r_timeout;
  assign fatal_pulse      = r_fatal;

`ifdef ARB_STATS_EN
  logic [15:0] r_stat_ok;
  logic [15:0] r_stat_err;

  // Count final outcomes as each frame completes, holding at full scale
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_ok  <= 16'h0000;
      r_stat_err <= 16'h0000;
    end else if (r_state == ST_DONE) begin
      if (r_code == CODE_OKAY && r_stat_ok != 16'hFFFF)
        r_stat_ok <= r_stat_ok + 1'b1;
      if (r_code == CODE_ERROR && r_stat_err != 16'hFFFF)
        r_stat_err <= r_stat_err + 1'b1;
    end
  end

  assign stat_ok  = r_stat_ok;
  assign stat_err = r_stat_err;
`else
  assign stat_ok  = 16'h0000;
  assign stat_err = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_link_arbiter.sv
// Directed self-checking bench for frame_link_arbiter.
module tb_frame_link_arbiter;
  import frame_link_arbiter_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [FRAME_W-1:0] j_frame;
  logic               j_valid;
  logic               j_ready;
  logic [FRAME_W-1:0] t_frame;
  logic               t_valid;
  logic               t_ready;
  logic [FRAME_W-1:0] core_frame;
  logic               core_fin_j_valid;
  logic               core_fin_t_valid;
  logic               core_conf_jawny;
  logic               core_conf_tajny;
  logic [7:0]         core_conf_code;
  logic               j_done;
  logic               t_done;
  logic [7:0]         done_code;
  logic               busy;
  logic               timeout_pulse;
  logic               fatal_pulse;
  logic [15:0]        stat_ok;
  logic [15:0]        stat_err;

  int compared   = 0;
  int mismatched = 0;
  int tbCycle    = 0;
  int finJCount  = 0;
  int timeoutCount = 0;
  int jDoneCount = 0;

  localparam logic [FRAME_W-1:0] FA = {75{8'hA1}};
  localparam logic [FRAME_W-1:0] FB = {75{8'hB2}};
  localparam logic [FRAME_W-1:0] FC = {8'h3C, {74{8'h5A}}};
  localparam logic [FRAME_W-1:0] FD = {{74{8'hC3}}, 8'h0D};
  localparam logic [FRAME_W-1:0] FE = {75{8'hE7}};

`ifdef ARB_STATS_EN
  localparam int EXP_OK  = 5;
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_OK  = 0;
  localparam int EXP_ERR = 0;
`endif

  always #5 clk = ~clk;

  frame_link_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .j_frame          (j_frame),
    .j_valid          (j_valid),
    .j_ready          (j_ready),
    .t_frame          (t_frame),
    .t_valid          (t_valid),
    .t_ready          (t_ready),
    .core_frame       (core_frame),
    .core_fin_j_valid (core_fin_j_valid),
    .core_fin_t_valid (core_fin_t_valid),
    .core_conf_jawny  (core_conf_jawny),
    .core_conf_tajny  (core_conf_tajny),
    .core_conf_code   (core_conf_code),
    .j_done           (j_done),
    .t_done           (t_done),
    .done_code        (done_code),
    .busy             (busy),
    .timeout_pulse    (timeout_pulse),
    .fatal_pulse      (fatal_pulse),
    .stat_ok          (stat_ok),
    .stat_err         (stat_err)
  );

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (core_fin_j_valid) finJCount++;
    if (timeout_pulse)    timeoutCount++;
    if (j_done)           jDoneCount++;
  end

  // Flag order: j_ready t_ready busy fin_j fin_t j_done t_done timeout fatal
  function automatic logic [FRAME_W-1:0] flags();
    return FRAME_W'({j_ready, t_ready, busy, core_fin_j_valid, core_fin_t_valid,
                     j_done, t_done, timeout_pulse, fatal_pulse});
  endfunction

  function automatic logic sigSel(input int which);
    case (which)
      0:       return core_fin_j_valid;
      1:       return core_fin_t_valid;
      2:       return core_fin_j_valid | core_fin_t_valid;
      3:       return j_done;
      default: return t_done;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      tbCycle++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [FRAME_W-1:0] observed,
                             input logic [FRAME_W-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic jv, input logic [FRAME_W-1:0] jf,
                               input logic tv, input logic [FRAME_W-1:0] tf);
    j_valid = jv;
    j_frame = jf;
    t_valid = tv;
    t_frame = tf;
  endtask

  task automatic applyConfirm(input logic cj, input logic ct, input logic [7:0] code);
    core_conf_jawny = cj;
    core_conf_tajny = ct;
    core_conf_code  = code;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    applyConfirm(1'b0, 1'b0, 8'h00);
    tick(2);
    rst = 1'b0;
  endtask

  task automatic waitFor(input int which, input int budget, output logic seen);
    seen = sigSel(which);
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      seen = sigSel(which);
    end
  endtask

  // Serve one granted frame with an OKAY confirm in the first WAIT_CONF cycle
  task automatic serveOne(input side_t side, input logic [FRAME_W-1:0] frame, input string tag);
    logic seen;
    waitFor(2, 10, seen);
    checkOutput({tag, "_fin_seen"}, FRAME_W'(seen), FRAME_W'(1'b1));
    checkOutput({tag, "_fin_side"}, FRAME_W'({core_fin_t_valid, core_fin_j_valid}), FRAME_W'(side));
    checkOutput({tag, "_frame"}, core_frame, frame);
    tick(1);
    applyConfirm(side[0], side[1], CODE_OKAY);
    tick(1);
    applyConfirm(1'b0, 1'b0, 8'h00);
    tick(1);
    checkOutput({tag, "_done_side"}, FRAME_W'({t_done, j_done}), FRAME_W'(side));
    checkOutput({tag, "_done_code"}, FRAME_W'(done_code), FRAME_W'(8'h05));
    tick(1);
  endtask

  initial begin
    logic seen;
    int   lastFin;
    int   baseTimeout;
    int   baseFinJ;
    int   baseJDone;

    // Reset state
    doReset();
    checkOutput("rst_flags", flags(), FRAME_W'(9'b110000000));
    checkOutput("rst_done_code", FRAME_W'(done_code), '0);
    checkOutput("rst_core_frame", core_frame, '0);
    checkOutput("rst_stats", FRAME_W'({stat_ok, stat_err}), '0);

    // Single jawny frame, OKAY: ISSUE at cycle 0, done at cycle 3, ready the cycle after
    applyStimulus(1'b1, FA, 1'b0, '0);
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t1_loaded", flags(), FRAME_W'(9'b010000000));
    tick(1);
    checkOutput("t1_issue", flags(), FRAME_W'(9'b011100000));
    checkOutput("t1_frame", core_frame, FA);
    tick(1);
    checkOutput("t1_wait", flags(), FRAME_W'(9'b011000000));
    applyConfirm(1'b1, 1'b0, CODE_OKAY);
    tick(1);
    applyConfirm(1'b0, 1'b0, 8'h00);
    checkOutput("t1_done_state", flags(), FRAME_W'(9'b011000000));
    tick(1);
    checkOutput("t1_done_pulse", flags(), FRAME_W'(9'b010001000));
    checkOutput("t1_done_code", FRAME_W'(done_code), FRAME_W'(8'h05));
    tick(1);
    checkOutput("t1_ready_back", flags(), FRAME_W'(9'b110000000));

    // Both full out of reset: order j, t, j, t
    doReset();
    applyStimulus(1'b1, FA, 1'b1, FB);
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    serveOne(JAWNY, FA, "t2_a");
    serveOne(TAJNY, FB, "t2_b");
    applyStimulus(1'b1, FC, 1'b1, FD);
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    serveOne(JAWNY, FC, "t2_c");
    serveOne(TAJNY, FD, "t2_d");

    // Tajny: ERROR, unknown code, ERROR, then OKAY; re-issues 1+1+450 cycles apart
    baseTimeout = timeoutCount;
    applyStimulus(1'b0, '0, 1'b1, FE);
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    lastFin = 0;
    for (int a = 0; a < 4; a++) begin
      waitFor(1, 600, seen);
      checkOutput($sformatf("t3_fin%0d_seen", a), FRAME_W'(seen), FRAME_W'(1'b1));
      if (a > 0)
        checkOutput($sformatf("t3_fin%0d_gap", a), FRAME_W'(tbCycle - lastFin), FRAME_W'(452));
      lastFin = tbCycle;
      tick(1);
      applyConfirm(1'b0, 1'b1, (a == 3) ? CODE_OKAY : ((a == 1) ? 8'h33 : CODE_ERROR));
      tick(1);
      applyConfirm(1'b0, 1'b0, 8'h00);
      if (a == 0) begin
        tick(5);
        applyConfirm(1'b0, 1'b1, CODE_OKAY);
        tick(1);
        applyConfirm(1'b0, 1'b0, 8'h00);
        checkOutput("t3_backoff_ignores", flags(), FRAME_W'(9'b101000000));
      end
    end
    tick(1);
    checkOutput("t3_done_pulse", FRAME_W'(t_done), FRAME_W'(1'b1));
    checkOutput("t3_done_code", FRAME_W'(done_code), FRAME_W'(8'h05));
    tick(2);
    checkOutput("t3_no_timeouts", FRAME_W'(timeoutCount - baseTimeout), '0);

    // Jawny, no confirm ever: 4 timeouts, final code ERROR
    baseTimeout = timeoutCount;
    baseFinJ    = finJCount;
    applyStimulus(1'b1, FB, 1'b0, '0);
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    lastFin = 0;
    for (int a = 0; a < 4; a++) begin
      waitFor(0, 1600, seen);
      checkOutput($sformatf("t4_fin%0d_seen", a), FRAME_W'(seen), FRAME_W'(1'b1));
      if (a > 0)
        checkOutput($sformatf("t4_fin%0d_gap", a), FRAME_W'(tbCycle - lastFin), FRAME_W'(1475));
      lastFin = tbCycle;
      tick(1);
    end
    waitFor(3, 1200, seen);
    checkOutput("t4_done_seen", FRAME_W'(seen), FRAME_W'(1'b1));
    checkOutput("t4_done_latency", FRAME_W'(tbCycle - lastFin), FRAME_W'(1026));
    checkOutput("t4_done_code", FRAME_W'(done_code), FRAME_W'(8'h04));
    tick(2);
    checkOutput("t4_timeouts", FRAME_W'(timeoutCount - baseTimeout), FRAME_W'(4));
    checkOutput("t4_issues", FRAME_W'(finJCount - baseFinJ), FRAME_W'(4));
    checkOutput("t4_stat_ok", FRAME_W'(stat_ok), FRAME_W'(EXP_OK));
    checkOutput("t4_stat_err", FRAME_W'(stat_err), FRAME_W'(EXP_ERR));

    // Both full, jawny in flight; tajny confirm ignored, then FATAL flushes both
    doReset();
    applyStimulus(1'b1, FA, 1'b1, FB);
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    waitFor(0, 10, seen);
    checkOutput("t5_fin_seen", FRAME_W'(seen), FRAME_W'(1'b1));
    tick(1);
    applyConfirm(1'b0, 1'b1, CODE_OKAY);
    tick(1);
    checkOutput("t5_other_ignored", flags(), FRAME_W'(9'b001000000));
    applyConfirm(1'b1, 1'b0, CODE_FATAL);
    tick(1);
    applyConfirm(1'b0, 1'b0, 8'h00);
    checkOutput("t5_fatal_flags", flags(), FRAME_W'(9'b000001101));
    checkOutput("t5_fatal_code", FRAME_W'(done_code), FRAME_W'(8'h08));
    tick(1);
    checkOutput("t5_after_flush", flags(), FRAME_W'(9'b110000000));
    tick(3);
    checkOutput("t5_stays_idle", flags(), FRAME_W'(9'b110000000));

    // Reset during BACKOFF: frame dropped, no done pulse
    applyStimulus(1'b1, FC, 1'b0, '0);
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    waitFor(0, 10, seen);
    checkOutput("t6_fin_seen", FRAME_W'(seen), FRAME_W'(1'b1));
    tick(1);
    applyConfirm(1'b1, 1'b0, CODE_ERROR);
    tick(1);
    applyConfirm(1'b0, 1'b0, 8'h00);
    tick(20);
    checkOutput("t6_in_backoff", flags(), FRAME_W'(9'b011000000));
    baseJDone = jDoneCount;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("t6_rst_flags", flags(), FRAME_W'(9'b110000000));
    checkOutput("t6_rst_code", FRAME_W'(done_code), '0);
    checkOutput("t6_rst_frame", core_frame, '0);
    checkOutput("t6_rst_stats", FRAME_W'({stat_ok, stat_err}), '0);
    tick(600);
    checkOutput("t6_still_idle", flags(), FRAME_W'(9'b110000000));
    checkOutput("t6_no_done", FRAME_W'(jDoneCount - baseJDone), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
